// File: rtl/sbox_lane_engine_if.sv
// Handshake bundle for sbox_lane_engine: input side, output side and flush.
// The master drives transactions in and takes results out; the engine is the slave.
interface sbox_lane_engine_if #(
  parameter int unsigned LANES = 16,
  parameter int unsigned TAG_W = 4
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic               in_inv;
  logic [8*LANES-1:0] in_data;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [8*LANES-1:0] out_data;
  logic [TAG_W-1:0]   out_tag;
  logic               out_inv;
  logic               err;

  modport master (
    output flush, in_valid, in_inv, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_inv, err
  );

  modport slave (
    input  flush, in_valid, in_inv, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_inv, err
  );
endinterface

// File: rtl/sbox_lane_engine.sv
// Two-stage elastic AES SubBytes / InvSubBytes engine over LANES independent byte lanes.
// S-box is computed as GF(2^8) inversion plus the FIPS-197 affine map, so one function
// body serves both directions. Optional self-check (macro SBOX_SELFCHECK_EN) keeps a copy
// of the source bytes in S2 and flags err when the opposite map does not return them.
module sbox_lane_engine #(
  parameter int unsigned LANES = 16,
  parameter int unsigned TAG_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  sbox_lane_engine_if.slave bus
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = product of a^(2^k), k = 1..7; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int k = 1; k < 8; k++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  logic               s1_valid_q;
  logic               s1_inv_q;
  logic [8*LANES-1:0] s1_data_q;
  logic [TAG_W-1:0]   s1_tag_q;
  logic               s2_valid_q;
  logic               s2_inv_q;
  logic [8*LANES-1:0] s2_data_q;
  logic [TAG_W-1:0]   s2_tag_q;
  logic [8*LANES-1:0] sub_d;
  logic               out_xfer;
  logic               s1_adv;
  logic               in_xfer;

  assign out_xfer = s2_valid_q && bus.out_ready;
  assign s1_adv   = s1_valid_q && (!s2_valid_q || out_xfer);
  // rst_n term keeps in_ready low throughout an asynchronous reset.
  assign bus.in_ready = rst_n && !bus.flush && (!s1_valid_q || s1_adv);
  assign in_xfer      = bus.in_valid && bus.in_ready;

  // Per-lane substitution of the S1 bytes, direction chosen by the captured mode.
  always_comb begin
    sub_d = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sub_d[8*i +: 8] = s1_inv_q ? inv_sbox(s1_data_q[8*i +: 8])
                                 : fwd_sbox(s1_data_q[8*i +: 8]);
    end
  end

  // Pipeline stage registers with flush and elastic advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_inv_q   <= 1'b0;
      s1_data_q  <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_inv_q   <= 1'b0;
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
    end else if (bus.flush) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (s1_adv) begin
        s2_valid_q <= 1'b1;
        s2_data_q  <= sub_d;
        s2_tag_q   <= s1_tag_q;
        s2_inv_q   <= s1_inv_q;
      end else if (out_xfer) begin
        s2_valid_q <= 1'b0;
      end
      if (in_xfer) begin
        s1_valid_q <= 1'b1;
        s1_data_q  <= bus.in_data;
        s1_tag_q   <= bus.in_tag;
        s1_inv_q   <= bus.in_inv;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_tag   = s2_tag_q;
  assign bus.out_inv   = s2_inv_q;

`ifdef SBOX_SELFCHECK_EN
  logic [8*LANES-1:0] s2_src_q;
  logic               chk_mismatch;

  // Source bytes travel alongside the result so it can be mapped back and compared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_src_q <= '0;
    end else if (!bus.flush && s1_adv) begin
      s2_src_q <= s1_data_q;
    end
  end

  // Opposite mapping of every output lane must reproduce the stored source byte.
  always_comb begin
    chk_mismatch = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if ((s2_inv_q ? fwd_sbox(s2_data_q[8*i +: 8]) : inv_sbox(s2_data_q[8*i +: 8]))
          != s2_src_q[8*i +: 8]) begin
        chk_mismatch = 1'b1;
      end
    end
  end

  assign bus.err = s2_valid_q && chk_mismatch;
`else
  assign bus.err = 1'b0;
`endif

endmodule
